// File: rtl/activation_sequencer.sv
// Timestep controller for the activation_unit array: clear, NUM_TIMESTEPS stepped beats, capture, result handshake.
// Optional feature: define ACT_SEQ_ABORT_EN to add an abort input that cancels an in-flight window.
module activation_sequencer #(
  parameter int NUM_NEURONS   = 3,
  parameter int TIMER_WIDTH   = 5,
  parameter int NUM_TIMESTEPS = 16,
  parameter int STEP_W        = 5
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
`ifdef ACT_SEQ_ABORT_EN
  input  logic                               abort,
`endif
  output logic                               busy,
  input  logic                               mp_valid,
  output logic                               mp_ready,
  output logic                               act_clear,
  output logic                               act_en,
  output logic [STEP_W-1:0]                  timestep,
  input  logic [NUM_NEURONS*TIMER_WIDTH-1:0] spikes_in,
  output logic [NUM_NEURONS*TIMER_WIDTH-1:0] result_data,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic                               done
);
  localparam int DW = NUM_NEURONS * TIMER_WIDTH;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_TIMESTEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_MP,
    S_STEP,
    S_DRAIN,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] ts_q, ts_d;
  logic [DW-1:0]     rd_q, rd_d;
  logic              done_q, done_d;
  logic              abclr_q, abclr_d;
  logic              abort_req;

`ifdef ACT_SEQ_ABORT_EN
  assign abort_req = abort && (state_q != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    abclr_d = 1'b0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        ts_d    = '0;
        state_d = S_WAIT_MP;
      end
      S_WAIT_MP: if (mp_valid) state_d = S_STEP;
      S_STEP: begin
        if (ts_q == LAST_STEP) begin
          state_d = S_DRAIN;
        end else begin
          ts_d    = ts_q + STEP_W'(1);
          state_d = S_WAIT_MP;
        end
      end
      S_DRAIN:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        rd_d    = spikes_in;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (result_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default:   state_d = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle and leaves a clear pulse behind.
    if (abort_req) begin
      state_d = S_IDLE;
      ts_d    = ts_q;
      rd_d    = rd_q;
      done_d  = 1'b0;
      abclr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ts_q    <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      abclr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      abclr_q <= abclr_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mp_ready     = (state_q == S_WAIT_MP);
  assign act_clear    = (state_q == S_CLEAR) || abclr_q;
  assign act_en       = (state_q == S_STEP);
  assign result_valid = (state_q == S_OUTPUT);
  assign timestep     = ts_q;
  assign result_data  = rd_q;
  assign done         = done_q;
endmodule
